alu_issue: RTL and testbench

Execute-stage issue buffer that sits directly upstream of the ALU's bitwise, arithmetic and shift units. It accepts one decoded ALU operation per cycle from decode over a valid/ready handshake and registers the two 32-bit operands. It presents them to the units with a one-hot set of unit enables, where a deasserted enable forces that unit's output to zero. A 2-entry skid buffer gives full throughput with a fully registered `in_ready`, and preserves order across downstream stalls.

---
 rtl/alu_issue.sv | 136 +++++++++++++
 tb/tb_alu_issue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue -- execute-stage issue buffer in front of the ALU units.
//
// Accepts one decoded ALU operation per cycle over a valid/ready handshake,
// decodes the opcode at capture and holds the operation in a two-entry
// buffer. The main entry drives the outputs. The skid entry absorbs the one
// extra operation that arrives in the cycle a downstream stall begins. Using
// the skid entry keeps in_ready a pure register output.
//
// Ports
//   clock, reset                 clock; asynchronous active-low reset
//   flush                        synchronous discard of both entries
//   in_valid/in_ready            upstream handshake (in_ready = !skid valid)
//   in_opcode, in_shamt          opcode and shift amount
//   in_A, in_B                   operands
//   out_valid/out_ready          downstream handshake
//   data_operandA/B, out_shamt   registered operands of the main entry
//   add/sub/and/or/sll/sra_enable one-hot unit enables, zero when !out_valid
//   illegal_op                   main entry holds an unsupported opcode
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [4:0]       in_shamt,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  output logic [4:0]       out_shamt,
  output logic             add_enable,
  output logic             sub_enable,
  output logic             and_enable,
  output logic             or_enable,
  output logic             sll_enable,
  output logic             sra_enable,
  output logic             illegal_op
);

  // Decoded form: {illegal, sra, sll, or, and, sub, add}
  function automatic logic [6:0] decode_op(input logic [4:0] op);
    logic [6:0] d;
    d = 7'b0;
    case (op)
      5'b00000: d[0] = 1'b1;
      5'b00001: d[1] = 1'b1;
      5'b00010: d[2] = 1'b1;
      5'b00011: d[3] = 1'b1;
      5'b00100: d[4] = 1'b1;
      5'b00101: d[5] = 1'b1;
      default:  d[6] = 1'b1;
    endcase
    return d;
  endfunction

  logic             main_vld, skid_vld;
  logic [WIDTH-1:0] main_a, main_b, skid_a, skid_b;
  logic [4:0]       main_sh, skid_sh;
  logic [6:0]       main_dec, skid_dec;
  logic [6:0]       in_dec;
  logic             in_xfer;
  logic             main_free;

  assign in_dec    = decode_op(in_opcode);
  assign in_xfer   = in_valid & in_ready;
  // Main can take a new entry when it is empty or its entry leaves this cycle.
  assign main_free = ~main_vld | out_ready;

  // Capture stage: main/skid entry registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_a   <= '0;
      main_b   <= '0;
      main_sh  <= '0;
      main_dec <= '0;
      skid_a   <= '0;
      skid_b   <= '0;
      skid_sh  <= '0;
      skid_dec <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_a   <= skid_a;
        main_b   <= skid_b;
        main_sh  <= skid_sh;
        main_dec <= skid_dec;
        skid_vld <= in_xfer;
        if (in_xfer) begin
          skid_a   <= in_A;
          skid_b   <= in_B;
          skid_sh  <= in_shamt;
          skid_dec <= in_dec;
        end
      end else begin
        main_vld <= in_xfer;
        if (in_xfer) begin
          main_a   <= in_A;
          main_b   <= in_B;
          main_sh  <= in_shamt;
          main_dec <= in_dec;
        end
      end
    end else if (in_xfer) begin
      skid_vld <= 1'b1;
      skid_a   <= in_A;
      skid_b   <= in_B;
      skid_sh  <= in_shamt;
      skid_dec <= in_dec;
    end
  end

  // Output stage: enables and illegal flag qualified by the main valid bit
  assign in_ready      = ~skid_vld;
  assign out_valid     = main_vld;
  assign data_operandA = main_a;
  assign data_operandB = main_b;
  assign out_shamt     = main_sh;
  assign add_enable    = main_vld & main_dec[0];
  assign sub_enable    = main_vld & main_dec[1];
  assign and_enable    = main_vld & main_dec[2];
  assign or_enable     = main_vld & main_dec[3];
  assign sll_enable    = main_vld & main_dec[4];
  assign sra_enable    = main_vld & main_dec[5];
  assign illegal_op    = main_vld & main_dec[6];

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_opcode, in_shamt, out_shamt;
  logic [31:0] in_A, in_B, data_operandA, data_operandB;
  logic        add_enable, sub_enable, and_enable, or_enable, sll_enable, sra_enable, illegal_op;
  logic [5:0]  en_bus;

  assign en_bus = {sra_enable, sll_enable, or_enable, and_enable, sub_enable, add_enable};

  always #5 clock = ~clock;

  alu_issue #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_shamt(in_shamt), .in_A(in_A), .in_B(in_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .out_shamt(out_shamt),
    .add_enable(add_enable), .sub_enable(sub_enable), .and_enable(and_enable),
    .or_enable(or_enable), .sll_enable(sll_enable), .sra_enable(sra_enable),
    .illegal_op(illegal_op)
  );

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  exp_en;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [5:0]  en;
    logic        ill;
  } item_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t  vecs[9];
  item_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_opcode = op; in_shamt = sh; in_A = a; in_B = b;
  endtask

  function automatic logic [5:0] ref_en(input logic [4:0] op);
    case (op)
      5'd0: return 6'b000001;
      5'd1: return 6'b000010;
      5'd2: return 6'b000100;
      5'd3: return 6'b001000;
      5'd4: return 6'b010000;
      5'd5: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  initial begin
    vecs[0] = '{5'b00010, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 6'b000100, 1'b0};
    vecs[1] = '{5'b00011, 5'd1, 32'h12345678, 32'h0F0F0F0F, 6'b001000, 1'b0};
    vecs[2] = '{5'b00000, 5'd2, 32'hFFFFFFFF, 32'h00000001, 6'b000001, 1'b0};
    vecs[3] = '{5'b00001, 5'd3, 32'h80000000, 32'h7FFFFFFF, 6'b000010, 1'b0};
    vecs[4] = '{5'b00100, 5'd4, 32'h0000000F, 32'h00000000, 6'b010000, 1'b0};
    vecs[5] = '{5'b00101, 5'd31, 32'h80000001, 32'hA5A5A5A5, 6'b100000, 1'b0};
    vecs[6] = '{5'b01111, 5'd0, 32'hDEADBEEF, 32'h00000000, 6'b000000, 1'b1};
    vecs[7] = '{5'b00110, 5'd7, 32'h00000006, 32'h00000007, 6'b000000, 1'b1};
    vecs[8] = '{5'b11111, 5'd9, 32'hCAFEF00D, 32'h55555555, 6'b000000, 1'b1};

    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_enables", {illegal_op, en_bus}, 7'b0);
    chk("rst_operands", {data_operandA, data_operandB, out_shamt}, 69'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;

    // Back-to-back streaming of the vector table with out_ready held high
    drive(1'b1, vecs[0].op, vecs[0].sh, vecs[0].a, vecs[0].b);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_en", i), {illegal_op, en_bus}, {vecs[i].exp_ill, vecs[i].exp_en});
      chk($sformatf("vec%0d_data", i), {data_operandA, data_operandB, out_shamt},
          {vecs[i].a, vecs[i].b, vecs[i].sh});
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      if (i < 8) drive(1'b1, vecs[i+1].op, vecs[i+1].sh, vecs[i+1].a, vecs[i+1].b);
      else       drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    end
    step();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_en", en_bus, 6'b0);

    // Skid: A=1..4, out_ready low for three cycles starting with op 2
    drive(1'b1, 5'd0, 5'd0, 32'd1, 32'd0);
    step();
    chk("skid_a1", {out_valid, data_operandA}, {1'b1, 32'd1});
    drive(1'b1, 5'd0, 5'd0, 32'd2, 32'd0); out_ready = 1'b0;
    step();
    chk("skid_hold1", {out_valid, data_operandA}, {1'b1, 32'd1});
    chk("skid_in_ready_fall", in_ready, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 32'd3, 32'd0);
    step();
    chk("skid_hold2", {out_valid, data_operandA, in_ready}, {1'b1, 32'd1, 1'b0});
    step();
    chk("skid_hold3", {out_valid, data_operandA, in_ready}, {1'b1, 32'd1, 1'b0});
    out_ready = 1'b1;
    step();
    chk("skid_a2", {out_valid, data_operandA}, {1'b1, 32'd2});
    chk("skid_in_ready_rise", in_ready, 1'b1);
    step();
    chk("skid_a3", {out_valid, data_operandA}, {1'b1, 32'd3});
    drive(1'b1, 5'd0, 5'd0, 32'd4, 32'd0);
    step();
    chk("skid_a4", {out_valid, data_operandA}, {1'b1, 32'd4});
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    step();
    chk("skid_empty", out_valid, 1'b0);

    // Flush with both entries full and in_valid held high
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd0, 32'd10, 32'd0);
    step();
    drive(1'b1, 5'd1, 5'd0, 32'd11, 32'd0);
    step();
    chk("flush_full", {out_valid, in_ready}, {1'b1, 1'b0});
    drive(1'b1, 5'd1, 5'd0, 32'd12, 32'd0); flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_en", en_bus, 6'b0);
    // Flush with only main full drops an input that is actually handshaken
    drive(1'b1, 5'd1, 5'd0, 32'd13, 32'd0);
    step();
    drive(1'b1, 5'd1, 5'd0, 32'd14, 32'd0); flush = 1'b1;
    step();
    flush = 1'b0; drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0); out_ready = 1'b1;
    chk("flush2_state", {out_valid, in_ready}, {1'b0, 1'b1});
    step();
    chk("flush2_dropped", out_valid, 1'b0);

    // Asynchronous reset between edges with an AND op on the outputs
    drive(1'b1, 5'b00010, 5'd3, 32'hF0F0F0F0, 32'hFF00FF00);
    step();
    chk("arst_pre", {out_valid, and_enable}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid_en", {out_valid, and_enable, en_bus}, 8'd0);
    chk("arst_operands", {data_operandA, data_operandB}, 64'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    step();
    #2 reset = 1'b1;
    step();
    chk("arst_after_first", {out_valid, and_enable, data_operandA}, {2'b11, 32'hF0F0F0F0});
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    step();

    // Randomised scoreboard run
    begin
      int    n_acc = 0;
      int    cyc = 0;
      int    bad_rnd = 0;
      item_t it, ex;
      while (cyc < 80000 && !(n_acc >= 10000 && sb.size() == 0)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (n_acc < 10000 && $urandom_range(0, 3) != 0)
          drive(1'b1, 5'($urandom_range(0, 7) == 7 ? $urandom_range(6, 31) : $urandom_range(0, 5)),
                5'($urandom), $urandom, $urandom);
        else
          drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        if (!out_valid && (en_bus != 6'b0 || illegal_op)) begin
          bad_rnd++;
          chk("rnd_en_while_idle", {illegal_op, en_bus}, 7'b0);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("rnd_unexpected_output", 1'b1, 1'b0);
          end else begin
            ex = sb.pop_front();
            if ({data_operandA, data_operandB, out_shamt, en_bus, illegal_op} !==
                {ex.a, ex.b, ex.sh, ex.en, ex.ill}) begin
              bad_rnd++;
              chk("rnd_order", {data_operandA, data_operandB, out_shamt, en_bus, illegal_op},
                  {ex.a, ex.b, ex.sh, ex.en, ex.ill});
            end
          end
        end
        if (in_valid && in_ready) begin
          it.a = in_A; it.b = in_B; it.sh = in_shamt;
          it.en = ref_en(in_opcode); it.ill = (in_opcode > 5'd5);
          sb.push_back(it);
          n_acc++;
        end
        step();
        cyc++;
      end
      chk("rnd_clean", bad_rnd, 0);
      chk("rnd_drained", {n_acc >= 10000, sb.size() == 0}, 2'b11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
